// File: rtl/command_page_fetcher.sv
// command_page_fetcher: caches command pages by tag and burst-fills a round-robin victim page on a miss
module command_page_fetcher #(
    parameter int PAGE_COUNT = 4,
    parameter int PAGE_BITS  = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [20:0]                   command_addr,
    input  logic                          flush,
    output logic                          command_ready,
    output logic [$clog2(PAGE_COUNT)-1:0] hit_slot,
    output logic                          mem_request,
    output logic [21:0]                   mem_address,
    output logic                          mem_last4,
    output logic                          mem_write_enable,
    output logic [31:0]                   mem_data_write,
    input  logic                          mem_ready,
    input  logic [31:0]                   mem_data_read,
    output logic                          fill_we,
    output logic [$clog2(PAGE_COUNT)-1:0] fill_slot,
    output logic [PAGE_BITS-1:0]          fill_addr,
    output logic [31:0]                   fill_data
);
    localparam int SW = $clog2(PAGE_COUNT);
    localparam int TW = 21 - PAGE_BITS;
    localparam logic [PAGE_BITS-1:0] LAST_WORD   = '1;
    localparam logic [PAGE_BITS-1:0] LAST4_START = PAGE_BITS'((1 << PAGE_BITS) - 4);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                state, state_next;
    logic [TW-1:0]         tags [PAGE_COUNT];
    logic [PAGE_COUNT-1:0] valid;
    logic [TW-1:0]         miss_tag;
    logic [SW-1:0]         victim, rr_ptr;
    logic [PAGE_BITS-1:0]  word_cnt;
    logic [TW-1:0]         cmd_tag;
    logic                  in_fill;
    logic                  unused_offset;

    assign cmd_tag          = command_addr[20:PAGE_BITS];
    assign unused_offset    = ^command_addr[PAGE_BITS-1:0];
    assign mem_write_enable = 1'b0;
    assign mem_data_write   = '0;
    assign in_fill          = state == FILL;

    // Tag match; scanning downward lets the lowest matching slot win
    always_comb begin
        command_ready = 1'b0;
        hit_slot = '0;
        for (int i = PAGE_COUNT - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == cmd_tag) begin
                command_ready = 1'b1;
                hit_slot = SW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clock) state <= !reset ? IDLE : state_next;

    // Next state and burst-side outputs, all quiet outside FILL
    always_comb begin
        state_next  = IDLE;
        mem_request = in_fill;
        fill_we     = in_fill && mem_ready;
        mem_last4   = in_fill && word_cnt >= LAST4_START;
        mem_address = in_fill ? {1'b0, miss_tag, word_cnt} : '0;
        fill_slot   = fill_we ? victim : '0;
        fill_addr   = fill_we ? word_cnt : '0;
        fill_data   = fill_we ? mem_data_read : '0;
        case (state)
            IDLE:    state_next = (!command_ready && !flush) ? FILL : IDLE;
            FILL:    state_next = flush ? IDLE : (mem_ready && word_cnt == LAST_WORD) ? DONE : FILL;
            default: state_next = IDLE;
        endcase
    end

    // Miss latch, word counter, valid bits and round-robin pointer; flush wins over any fill progress
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid    <= '0;
            word_cnt <= '0;
            rr_ptr   <= '0;
            victim   <= '0;
            miss_tag <= '0;
        end else if (flush) begin
            valid    <= '0;
            word_cnt <= '0;
        end else begin
            if (state == IDLE && !command_ready) begin
                miss_tag       <= cmd_tag;
                victim         <= rr_ptr;
                valid[rr_ptr]  <= 1'b0;
            end
            if (in_fill && mem_ready) word_cnt <= word_cnt + 1'b1;
            if (state == DONE) begin
                valid[victim] <= 1'b1;
                rr_ptr        <= rr_ptr + 1'b1;
            end
        end
    end

    // Tag written only on a completed fill; stale tags are masked by their valid bit
    always_ff @(posedge clock) if (reset && !flush && state == DONE) tags[victim] <= miss_tag;
endmodule

// File: doc/command_page_fetcher.md
COMMAND_PAGE_FETCHER -- requirements
Module: command_page_fetcher

Interface
REQ-001 SHALL have parameter PAGE_COUNT, default 4, number of cached command pages; legal values 2, 4 or 8.
REQ-002 SHALL have parameter PAGE_BITS, default 8, log2 of words per page, so a page holds 256 words of 32 bits.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port command_addr, input, 21 bits: word address of the next command; tag = [20:PAGE_BITS], offset = [PAGE_BITS-1:0].
REQ-006 SHALL have port flush, input, 1 bit: invalidate all pages.
REQ-007 SHALL have port command_ready, output, 1 bit: the page holding command_addr is valid.
REQ-008 SHALL have port hit_slot, output, log2(PAGE_COUNT) bits: slot holding command_addr; meaningful only while command_ready=1.
REQ-009 SHALL have port mem_request, output, 1 bit: memory read request.
REQ-010 SHALL have port mem_address, output, 22 bits: word read address = {1'b0, tag, offset}.
REQ-011 SHALL have port mem_last4, output, 1 bit: at most 4 words of the current burst remain to be accepted.
REQ-012 SHALL have port mem_write_enable, output, 1 bit; tied 0.
REQ-013 SHALL have port mem_data_write, output, 32 bits; tied 0.
REQ-014 SHALL have port mem_ready, input, 1 bit: mem_data_read is valid for mem_address this cycle.
REQ-015 SHALL have port mem_data_read, input, 32 bits: read data.
REQ-016 SHALL have port fill_we, output, 1 bit: write strobe to page RAM.
REQ-017 SHALL have port fill_slot, output, log2(PAGE_COUNT) bits: page RAM selected for the write.
REQ-018 SHALL have port fill_addr, output, PAGE_BITS bits: word address within the page RAM.
REQ-019 SHALL have port fill_data, output, 32 bits: data to write into the page RAM.

Function
REQ-020 SHALL keep per slot a tag register (21-PAGE_BITS bits) and a valid bit.
REQ-021 SHALL compute command_ready and hit_slot combinationally from command_addr, tags and valid bits; on a multi-match the lowest slot index wins.
REQ-022 SHALL implement FSM IDLE, FILL, DONE.
REQ-023 In IDLE with command_ready=0 and flush=0, SHALL latch miss_tag = command_addr tag and victim = the round-robin pointer, clear valid[victim], and enter FILL next cycle.
REQ-024 In FILL, SHALL hold mem_request=1 and mem_address={1'b0, miss_tag, word_cnt}, with word_cnt starting at 0.
REQ-025 On each FILL cycle with mem_ready=1, SHALL drive fill_we=1, fill_slot=victim, fill_addr=word_cnt and fill_data=mem_data_read in the same cycle, then increment word_cnt.
REQ-026 SHALL not alter word_cnt or mem_address while mem_ready=0; the memory side may stall indefinitely.
REQ-027 SHALL drive mem_last4=1 in FILL when word_cnt >= 2^PAGE_BITS-4.
REQ-028 On mem_ready with word_cnt = 2^PAGE_BITS-1, SHALL enter DONE, wrapping word_cnt to 0.
REQ-029 In DONE, SHALL write tag[victim]=miss_tag, set valid[victim]=1, advance the round-robin pointer modulo PAGE_COUNT, and return to IDLE; command_ready can rise the next cycle.
REQ-030 SHALL keep the fill bound to the latched miss_tag even if command_addr changes during FILL.
REQ-031 A flush in any state SHALL clear all valid bits next cycle; in FILL or DONE it SHALL also abort to IDLE with mem_request=0, and the victim SHALL stay invalid.
REQ-032 Outside FILL, SHALL keep mem_request=0, fill_we=0 and mem_last4=0.

Reset
REQ-033 While reset=0 at a clock edge, SHALL force IDLE, clear all valid bits and zero word_cnt and the round-robin pointer; tags are don't-care.
REQ-034 After reset, all outputs SHALL read 0.
REQ-035 Reset asserted mid-FILL SHALL abandon the burst immediately, with no completion in DONE.

Verification
REQ-036 Reset, then command_addr=0x000123 with mem_ready=1 every cycle -> 256 fill_we pulses at slot 0, addresses 0..255, mem_address 0x000100..0x0001FF, mem_last4 on the last 4, command_ready=1 two cycles after the last word, hit_slot=0.
REQ-037 Miss on tags 1,2,3,4,5 in sequence -> filled slots 0,1,2,3,0; tag 1 then misses and tag 5 hits on slot 0.
REQ-038 mem_ready toggles 1,0,0,1 during FILL -> fill_addr advances only on ready cycles; no duplicate or skipped words.
REQ-039 flush at word 100 of a fill -> mem_request drops next cycle, command_ready=0, and the next miss refills the same victim slot from word 0.
REQ-040 command_addr switches to another page mid-fill -> the fill completes for the original tag, then a new miss starts on the next slot.
